wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WriteEnable/WriteReg/WriteData from WB) and the multicycle mul/div unit (MDU).
- The pipeline always wins the port. MDU results are buffered in a small FIFO and drained into idle writeback slots.
- A starvation counter forces a pipeline bubble when MDU results wait too long.
- Exports a pending-destination mask so decode can stall RAW/WAW hazards against buffered MDU results.

Parameters:
- DEPTH, 2, MDU result FIFO entries; power of 2, >= 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before a forced bubble is requested; >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wb_we  input  1  pipeline writeback enable (WB stage WriteEnable)
- wb_rd  input  5  pipeline destination register
- wb_data  input  32  pipeline writeback data
- mdu_valid  input  1  MDU result valid
- mdu_ready  output  1  FIFO can accept; high when count < DEPTH
- mdu_rd  input  5  MDU destination register
- mdu_data  input  32  MDU result
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  5  register-file write address (registered)
- rf_wdata  output  32  register-file write data (registered)
- pipe_stall_req  output  1  request that the pipeline present no write next cycle
- pend_mask  output  32  bit i = 1 if any FIFO entry targets xi; bit 0 always 0
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (clk edge with rst=1, including mid-operation):
  - FIFO flushed, count=0, starve counter=0, state IDLE.
  - rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall_req=0, pend_mask=0.
  - mdu_ready=1 from the first cycle after reset.
- Push:
  - Occurs when mdu_valid && mdu_ready; {mdu_rd, mdu_data} is written at the tail.
  - mdu_ready depends only on registered count. When full, ready=0 even if a pop happens in the same cycle.
- Slot free:
  - The slot is free when wb_we==0 or wb_rd==0.
  - Pipeline write (wb_we=1, wb_rd!=0) in cycle N: rf_* = {1, wb_rd, wb_data} in cycle N+1. Latency is 1.
- Pop:
  - Occurs when the slot is free and count>0. The head is popped and rf_* = {1, head_rd, head_data} in cycle N+1.
  - If head_rd==0, the entry is popped with rf_we=0 in N+1.
  - Neither free nor popping: rf_we=0 in N+1; rf_waddr/rf_wdata hold their previous values.
- No bypass: an entry pushed in cycle N can pop no earlier than N+1, so minimum MDU-to-rf latency is 2 cycles.
- Simultaneous push and pop (count>0, not full): both happen and count is unchanged. Pointers wrap modulo DEPTH.
- FSM (registered state):
  - IDLE: count==0, starve counter=0.
    - Push -> PENDING.
  - PENDING: count>0.
    - Counter increments each cycle the head is not popped and clears on every pop.
    - Counter reaches STARVE_LIMIT -> FORCE.
    - Pop emptying the FIFO with no push in the same cycle -> IDLE.
  - FORCE: pipe_stall_req=1, registered and asserted for the whole state.
    - Pops continue whenever the slot is free.
    - If wb_we=1, wb_rd!=0 arrives anyway, the pipeline still wins.
    - On a pop: -> IDLE if the FIFO becomes empty, otherwise -> PENDING with counter cleared.
- pend_mask:
  - OR of one-hot(rd) over valid entries, excluding rd==0, derived from FIFO registers.
  - A push is visible in the mask the cycle after it; a pop is cleared the cycle after it.
  - Duplicate rd entries keep the bit set until the last one pops.
- Ordering: the arbiter never reorders MDU results. WAW/RAW avoidance against pend_mask is decode's responsibility.

Test Plan:
- Reset, then pipeline-only traffic: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF in cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; mdu_ready=1, pend_mask=0.
- MDU write into an idle pipeline: mdu_valid=1, mdu_rd=7, mdu_data=0x1234 in N, wb_we=0 throughout -> pend_mask[7]=1 in N+1; rf write {7, 0x1234} in N+2; pend_mask=0 in N+2.
- Fill and back-pressure: wb_we=1, wb_rd=3 every cycle; push rd=8 then rd=9 -> fifo_count=2, mdu_ready=0. Drop wb_we for one cycle -> rd=8 written next cycle, and mdu_ready=1 in the cycle after that pop.
- Starvation: one entry (rd=10) with wb_we=1, wb_rd=4 every cycle -> pipe_stall_req=1 after STARVE_LIMIT=8 waiting cycles. Bench drops wb_we -> rd=10 written next cycle, pipe_stall_req=0 once back in IDLE.
- rd=0 handling: MDU push with rd=0 -> pend_mask stays 0, entry pops in a free slot with rf_we=0, fifo_count returns to 0. Pipeline wb_rd=0 with wb_we=1 counts as a free slot and drains a pending entry.
- Reset mid-operation: FIFO holding 2 entries in FORCE, assert rst for one cycle -> fifo_count=0, pend_mask=0, pipe_stall_req=0, rf_we=0, and no buffered entry is ever written afterwards.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, MDU result stream,
// arbitrated register-file write and hazard/occupancy status.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [4:0]    mdu_rd;
    logic [31:0]   mdu_data;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          pipe_stall_req;
    logic [31:0]   pend_mask;
    logic [CW-1:0] fifo_count;

    modport master (
        output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall_req, pend_mask, fifo_count
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall_req, pend_mask, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port: the pipeline always wins,
// MDU results are buffered and drained into idle slots, with starvation relief.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] FORCE   = 2'd2;

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]    head_reg, tail_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic [SW-1:0]    starve_reg;
    logic [1:0]       state_reg;
    logic             rf_we_reg;
    logic [4:0]       rf_waddr_reg;
    logic [31:0]      rf_wdata_reg;

    logic             ready;
    logic             push;
    logic             pipe_wr;
    logic             pop;
    logic [4:0]       head_rd;
    logic [31:0]      head_data;
    logic [31:0]      entry_mask [DEPTH];
    logic [31:0]      mask_or;

    // Readiness looks only at the registered count, so a full FIFO refuses
    // a push even when it is draining in the same cycle.
    assign ready     = (count_reg < CW'(DEPTH));
    assign push      = bus.mdu_valid && ready;
    assign pipe_wr   = bus.wb_we && (bus.wb_rd != 5'd0);
    assign pop       = !pipe_wr && (count_reg != '0);
    assign head_rd   = rd_mem[head_reg];
    assign head_data = data_mem[head_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    // Storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_reg]   <= bus.mdu_rd;
            data_mem[tail_reg] <= bus.mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + AW'(1);
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            assign entry_mask[gi] = valid_reg[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        mask_or = 32'd0;
        for (int i = 0; i < DEPTH; i++)
            mask_or = mask_or | entry_mask[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            starve_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    starve_reg <= '0;
                    if (push)
                        state_reg <= PENDING;
                end
                PENDING: begin
                    if (pop) begin
                        starve_reg <= '0;
                        if (count_next == '0)
                            state_reg <= IDLE;
                    end else begin
                        starve_reg <= starve_reg + SW'(1);
                        if (starve_reg + SW'(1) == SW'(STARVE_LIMIT))
                            state_reg <= FORCE;
                    end
                end
                FORCE: begin
                    if (pop) begin
                        starve_reg <= '0;
                        state_reg  <= (count_next == '0) ? IDLE : PENDING;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    starve_reg <= '0;
                end
            endcase
        end
    end

    // A popped rd==0 entry consumes its slot but leaves the address/data held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 5'd0;
            rf_wdata_reg <= 32'd0;
        end else if (pipe_wr) begin
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= bus.wb_rd;
            rf_wdata_reg <= bus.wb_data;
        end else if (pop && head_rd != 5'd0) begin
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= head_rd;
            rf_wdata_reg <= head_data;
        end else begin
            rf_we_reg    <= 1'b0;
        end
    end

    assign bus.mdu_ready      = ready;
    assign bus.rf_we          = rf_we_reg;
    assign bus.rf_waddr       = rf_waddr_reg;
    assign bus.rf_wdata       = rf_wdata_reg;
    assign bus.pipe_stall_req = (state_reg == FORCE);
    assign bus.pend_mask      = {mask_or[31:1], 1'b0};
    assign bus.fifo_count     = count_reg;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: register-file writes are predicted into a scoreboard
// queue when stimulus is driven and popped when the DUT presents them.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    ent_t mdu_q[$];
    ent_t exp_q[$];

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus, update the model, then check the rf port.
    task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        ent_t e;
        logic exp_we;
        bit   push_ok;
        bus.wb_we     = we;
        bus.wb_rd     = rd;
        bus.wb_data   = d;
        bus.mdu_valid = mv;
        bus.mdu_rd    = mrd;
        bus.mdu_data  = md;
        push_ok = mv && (mdu_q.size() < DEPTH);
        exp_we  = 1'b0;
        if (we && rd != 5'd0) begin
            exp_we = 1'b1;
            e.rd = rd; e.data = d;
            exp_q.push_back(e);
        end else if (mdu_q.size() > 0) begin
            e = mdu_q.pop_front();
            if (e.rd != 5'd0) begin
                exp_we = 1'b1;
                exp_q.push_back(e);
            end
        end
        if (push_ok) begin
            e.rd = mrd; e.data = md;
            mdu_q.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
        n_checks++;
        if (bus.rf_we !== exp_we) begin
            n_fail++;
            $display("FAIL rf_we cycle %0d: got %b expected %b", cyc, bus.rf_we, exp_we);
        end
        if (exp_we) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.rf_waddr, bus.rf_wdata} !== {e.rd, e.data}) begin
                n_fail++;
                $display("FAIL rf_write cycle %0d: got x%0d=%h expected x%0d=%h",
                         cyc, bus.rf_waddr, bus.rf_wdata, e.rd, e.data);
            end
        end
        $display("cycle %0d: wb_we=%b wb_rd=%0d mdu_valid=%b mdu_rd=%0d -> rf_we=%b x%0d=%h count=%0d stall=%b",
                 cyc, we, rd, mv, mrd, bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                 bus.fifo_count, bus.pipe_stall_req);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.wb_we     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.mdu_valid = 1'b0;
        bus.mdu_rd    = 5'd0;
        bus.mdu_data  = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        mdu_q.delete();
        exp_q.delete();
        $display("cycle %0d: reset applied", cyc);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_rf: got %b/%0d/%h expected 0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        n_checks++;
        if (bus.pend_mask !== 32'd0 || bus.pipe_stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: mask=%h stall=%b expected 0/0", bus.pend_mask, bus.pipe_stall_req);
        end
        n_checks++;
        if (bus.mdu_ready !== 1'b1 || bus.fifo_count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: ready=%b count=%0d expected 1/0", bus.mdu_ready, bus.fifo_count);
        end
    endtask

    task automatic test_pipeline();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.rf_waddr !== 5'd5 || bus.mdu_ready !== 1'b1 || bus.pend_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL pipe_write: addr=%0d ready=%b mask=%h expected 5/1/0",
                     bus.rf_waddr, bus.mdu_ready, bus.pend_mask);
        end
        for (int i = 0; i < 6; i++)
            step(1'b1, 5'($urandom_range(31, 1)), $urandom, 1'b0, 5'd0, 32'd0);
        idle(1);
    endtask

    task automatic test_mdu_idle();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        n_checks++;
        if (bus.pend_mask !== 32'h0000_0080 || bus.fifo_count !== 2'd1) begin
            n_fail++;
            $display("FAIL mdu_pending: mask=%h count=%0d expected 00000080/1", bus.pend_mask, bus.fifo_count);
        end
        idle(1);
        n_checks++;
        if (bus.pend_mask !== 32'd0 || bus.fifo_count !== 2'd0 || bus.rf_waddr !== 5'd7) begin
            n_fail++;
            $display("FAIL mdu_drain: mask=%h count=%0d addr=%0d expected 0/0/7",
                     bus.pend_mask, bus.fifo_count, bus.rf_waddr);
        end
    endtask

    task automatic test_fill();
        step(1'b1, 5'd3, 32'hA0, 1'b1, 5'd8, 32'h808);
        step(1'b1, 5'd3, 32'hA1, 1'b1, 5'd9, 32'h909);
        n_checks++;
        if (bus.fifo_count !== 2'd2 || bus.mdu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d ready=%b expected 2/0", bus.fifo_count, bus.mdu_ready);
        end
        n_checks++;
        if (bus.pend_mask !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL fill_mask: mask=%h expected 00000300", bus.pend_mask);
        end
        step(1'b1, 5'd3, 32'hA2, 1'b1, 5'd11, 32'hBBB);
        n_checks++;
        if (bus.fifo_count !== 2'd2) begin
            n_fail++;
            $display("FAIL fill_reject: count=%0d expected 2", bus.fifo_count);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.fifo_count !== 2'd1 || bus.mdu_ready !== 1'b1 || bus.pend_mask !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL fill_pop: count=%0d ready=%b mask=%h expected 1/1/00000200",
                     bus.fifo_count, bus.mdu_ready, bus.pend_mask);
        end
        idle(2);
    endtask

    task automatic test_starve();
        step(1'b1, 5'd4, 32'h400, 1'b1, 5'd10, 32'hC0C0);
        for (int i = 1; i < LIMIT; i++) begin
            step(1'b1, 5'd4, 32'h400 + 32'(i), 1'b0, 5'd0, 32'd0);
            n_checks++;
            if (bus.pipe_stall_req !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_early wait %0d: stall=%b expected 0", i, bus.pipe_stall_req);
            end
        end
        step(1'b1, 5'd4, 32'h4FF, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.pipe_stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_force: stall=%b expected 1", bus.pipe_stall_req);
        end
        step(1'b1, 5'd4, 32'h4EE, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.pipe_stall_req !== 1'b1 || bus.fifo_count !== 2'd1) begin
            n_fail++;
            $display("FAIL starve_hold: stall=%b count=%0d expected 1/1", bus.pipe_stall_req, bus.fifo_count);
        end
        idle(1);
        n_checks++;
        if (bus.pipe_stall_req !== 1'b0 || bus.fifo_count !== 2'd0) begin
            n_fail++;
            $display("FAIL starve_release: stall=%b count=%0d expected 0/0", bus.pipe_stall_req, bus.fifo_count);
        end
    endtask

    task automatic test_rd0();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hEEEE);
        n_checks++;
        if (bus.pend_mask !== 32'd0 || bus.fifo_count !== 2'd1) begin
            n_fail++;
            $display("FAIL rd0_push: mask=%h count=%0d expected 0/1", bus.pend_mask, bus.fifo_count);
        end
        idle(1);
        n_checks++;
        if (bus.fifo_count !== 2'd0) begin
            n_fail++;
            $display("FAIL rd0_pop: count=%0d expected 0", bus.fifo_count);
        end
        step(1'b1, 5'd0, 32'h5555, 1'b1, 5'd12, 32'hC12);
        step(1'b1, 5'd0, 32'h6666, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.fifo_count !== 2'd0 || bus.rf_waddr !== 5'd12) begin
            n_fail++;
            $display("FAIL rd0_wb_free: count=%0d addr=%0d expected 0/12", bus.fifo_count, bus.rf_waddr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(13 + i), 32'hB000 + 32'(i));
            n_checks++;
            if (bus.fifo_count !== 2'd1) begin
                n_fail++;
                $display("FAIL b2b_count step %0d: count=%0d expected 1", i, bus.fifo_count);
            end
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hB100);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hB101);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.pend_mask !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL b2b_dup_mask: mask=%h expected 00002000", bus.pend_mask);
        end
        idle(2);
        n_checks++;
        if (bus.pend_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_mask_clear: mask=%h expected 0", bus.pend_mask);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 5'd4, 32'h1, 1'b1, 5'd20, 32'h2020);
        step(1'b1, 5'd4, 32'h2, 1'b1, 5'd21, 32'h2121);
        for (int i = 0; i < LIMIT; i++)
            step(1'b1, 5'd4, 32'h10 + 32'(i), 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.pipe_stall_req !== 1'b1 || bus.fifo_count !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_force: stall=%b count=%0d expected 1/2", bus.pipe_stall_req, bus.fifo_count);
        end
        do_reset();
        n_checks++;
        if (bus.fifo_count !== 2'd0 || bus.pend_mask !== 32'd0 ||
            bus.pipe_stall_req !== 1'b0 || bus.rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d mask=%h stall=%b rf_we=%b expected 0/0/0/0",
                     bus.fifo_count, bus.pend_mask, bus.pipe_stall_req, bus.rf_we);
        end
        idle(4);
        n_checks++;
        if (bus.fifo_count !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_after: count=%0d expected 0", bus.fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_mdu_idle();
        test_fill();
        test_starve();
        test_rd0();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
